ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  Execute stage plus EX/MEM pipeline register; consumes ID/EX register outputs.
//  Applies forwarding muxes, ALU-source select, ALU and dest-reg select, then registers results for MEM.
//  Optional iterative multiplier runs over multiple cycles and stalls upstream stages (PC, IF/ID, ID/EX).
// PARAMETERS
//  XLEN   32  datapath width; multiply takes XLEN busy cycles
//  REG_W  5   register-index width
// PORTS
//  One clock; reset is asynchronous and active-low.
//  clk           in   1      clock, rising edge
//  rst           in   1      async reset, active-low (0 = reset)
//  WBIn          in   2      WB control from ID/EX
//  MIn           in   2      MEM control from ID/EX
//  EXIn          in   5      [4] RegDst, [3] ALUSrc, [2:0] ALUOp
//  ReadData1In   in   XLEN   rs operand
//  ReadData2In   in   XLEN   rt operand
//  LdAddrIn      in   XLEN   sign-extended immediate
//  RtIn, RdIn    in   REG_W  dest candidates
//  ForwardA/B    in   2      00 reg, 01 WbWriteData, 10 MemAluResult, 11 reg
//  MemAluResult  in   XLEN   EX/MEM ALU result (forward source)
//  WbWriteData   in   XLEN   WB-stage write data (forward source)
//  WBOut, MOut   out  2      registered control to MEM
//  AluResultOut  out  XLEN   registered ALU/multiply result
//  WriteDataOut  out  XLEN   registered forwarded B (store data)
//  DestRegOut    out  REG_W  registered RegDst ? Rd : Rt
//  Stall         out  1      combinational; 1 freezes upstream stages
// BEHAVIOUR
//  - Reset: all outputs zero, FSM IDLE, counter 0; applies immediately, incl. mid-multiply (op abandoned).
//  - A = fwd(ForwardA, ReadData1In); Bf = fwd(ForwardB, ReadData2In); B = ALUSrc ? LdAddrIn : Bf.
//  - ALUOp: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed, 1/0), 101 nor, 110 mul, 111 -> result 0.
//  - Add/sub wrap mod 2^XLEN; no overflow flag. mul keeps low XLEN bits of product.
//  - Single-cycle op: all EX/MEM outputs load on the next rising edge; latency 1.
//  - FSM states: IDLE, BUSY, DONE.
//    IDLE & op==mul: Stall=1; edge latches A, B into operand regs, cnt<=0, ->BUSY; EX/MEM loads bubble.
//    BUSY: Stall=1; per edge one shift-add step, cnt++; at cnt==XLEN-1 -> DONE; EX/MEM loads bubble.
//    DONE: Stall=0; edge loads product, WB, M, dest into EX/MEM, -> IDLE.
//  - Bubble: WBOut=MOut=0; other EX/MEM fields hold their value.
//  - mul: Stall high XLEN+1 cycles; product in EX/MEM XLEN+2 edges after issue.
//  - Operands latched at issue; forward sources change while stalled and are ignored.
//  - Back-to-back mul: second mul arrives in IDLE after DONE and starts a fresh issue.
// CONFIGURATION
//  EX_MUL_EN defined: mul path, FSM and Stall as above.
//  EX_MUL_EN undefined: no multiplier logic; ALUOp 110 yields 0 in 1 cycle; Stall tied 0; FSM absent.
// STRUCTURE
//  Package ex_pkg: ALUOp codes, forward-select codes, FSM state enum, EX-field bit positions.
//  Sub-module ex_iter_mul: shift-add multiplier (start, operands, busy, done, product).
//  ex_iter_mul is instantiated only under EX_MUL_EN.
// TESTING
//  1 Reset: rst=0 mid-run -> all outputs 0, Stall 0; release -> add 5+7 gives AluResultOut=12 after 1 edge.
//  2 Forwarding: ForwardA=10, MemAluResult=9, ReadData1In=1, ALUOp=add, imm=3 (ALUSrc=1) -> AluResultOut=12.
//  3 slt/sub wrap: A=-1, B=1 slt -> 1; A=0, B=1 sub -> 32'hFFFFFFFF; RegDst=0 -> DestRegOut=RtIn.
//  4 mul (EX_MUL_EN): 6*7, Stall high 33 cycles, WBOut=0 meanwhile, then AluResultOut=42 plus WB/M/dest.
//  5 mul operand hold: change forward sources while BUSY -> result still 42.
//  6 mul abort: assert rst at cnt=10 -> IDLE, outputs 0; mul without EX_MUL_EN -> result 0, Stall 0.

Source files
------------

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared codes for the execute stage: ALU ops, forward selects, multiplier FSM states
package ex_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLT  = 3'b100,
        ALU_NOR  = 3'b101,
        ALU_MUL  = 3'b110,
        ALU_ZERO = 3'b111
    } aluOp_e;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_REG2 = 2'b11
    } fwdSel_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mulState_e;

    localparam int EX_REGDST   = 4;
    localparam int EX_ALUSRC   = 3;
    localparam int EX_ALUOP_HI = 2;

endpackage

// File: rtl/ex_iter_mul.sv
// rtl/ex_iter_mul.sv - shift-add multiplier, one partial product per cycle, XLEN busy cycles
// Only instantiated when EX_MUL_EN is defined.
module ex_iter_mul
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    mulState_e       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;

    // Only the low XLEN bits are kept, so the shifted multiplicand never needs to widen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= MUL_IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand   <= opA;
                        mplier  <= opB;
                        product <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    done  <= 1'b0;
                    state <= MUL_IDLE;
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute stage with forwarding and ALU, plus the EX/MEM pipeline register
// Define EX_MUL_EN to add the iterative multiplier and the upstream Stall it drives.
module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       WBIn,
    input  logic [1:0]       MIn,
    input  logic [4:0]       EXIn,
    input  logic [XLEN-1:0]  ReadData1In,
    input  logic [XLEN-1:0]  ReadData2In,
    input  logic [XLEN-1:0]  LdAddrIn,
    input  logic [REG_W-1:0] RtIn,
    input  logic [REG_W-1:0] RdIn,
    input  logic [1:0]       ForwardA,
    input  logic [1:0]       ForwardB,
    input  logic [XLEN-1:0]  MemAluResult,
    input  logic [XLEN-1:0]  WbWriteData,
    output logic [1:0]       WBOut,
    output logic [1:0]       MOut,
    output logic [XLEN-1:0]  AluResultOut,
    output logic [XLEN-1:0]  WriteDataOut,
    output logic [REG_W-1:0] DestRegOut,
    output logic             Stall
);

    aluOp_e          aluOp;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opBf;
    logic [XLEN-1:0] opB;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] exResult;
    logic            bubble;

    assign aluOp = aluOp_e'(EXIn[EX_ALUOP_HI:0]);

    always_comb begin
        opA = ReadData1In;
        case (fwdSel_e'(ForwardA))
            FWD_WB:  opA = WbWriteData;
            FWD_MEM: opA = MemAluResult;
            default: opA = ReadData1In;
        endcase
        opBf = ReadData2In;
        case (fwdSel_e'(ForwardB))
            FWD_WB:  opBf = WbWriteData;
            FWD_MEM: opBf = MemAluResult;
            default: opBf = ReadData2In;
        endcase
    end

    assign opB = EXIn[EX_ALUSRC] ? LdAddrIn : opBf;

    always_comb begin
        aluResult = '0;
        case (aluOp)
            ALU_ADD: aluResult = opA + opB;
            ALU_SUB: aluResult = opA - opB;
            ALU_AND: aluResult = opA & opB;
            ALU_OR:  aluResult = opA | opB;
            ALU_SLT: aluResult[0] = $signed(opA) < $signed(opB);
            ALU_NOR: aluResult = ~(opA | opB);
            default: aluResult = '0;
        endcase
    end

`ifdef EX_MUL_EN
    logic            mulBusy;
    logic            mulDone;
    logic            mulStart;
    logic [XLEN-1:0] mulProduct;

    // A mul seen while the multiplier is neither busy nor finishing is a fresh issue.
    assign mulStart = (aluOp == ALU_MUL) && !mulBusy && !mulDone;

    ex_iter_mul #(.XLEN(XLEN)) uMul (
        .clk     (clk),
        .rst     (rst),
        .start   (mulStart),
        .opA     (opA),
        .opB     (opB),
        .busy    (mulBusy),
        .done    (mulDone),
        .product (mulProduct)
    );

    // Gated by rst so Stall reads 0 while the stage is held in reset.
    assign Stall    = rst & (mulStart | mulBusy);
    assign bubble   = Stall;
    assign exResult = mulDone ? mulProduct : aluResult;
`else
    assign Stall    = 1'b0;
    assign bubble   = 1'b0;
    assign exResult = aluResult;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WBOut        <= '0;
            MOut         <= '0;
            AluResultOut <= '0;
            WriteDataOut <= '0;
            DestRegOut   <= '0;
        end else if (bubble) begin
            WBOut <= '0;
            MOut  <= '0;
        end else begin
            WBOut        <= WBIn;
            MOut         <= MIn;
            AluResultOut <= exResult;
            WriteDataOut <= opBf;
            DestRegOut   <= EXIn[EX_REGDST] ? RdIn : RtIn;
        end
    end

endmodule
